seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit seven-segment display.
- Sits directly upstream of the 2-to-4 anode decoder: drives the decoder's 2-bit select and enable, and presents the selected digit's hex nibble and decimal point to the hex-to-segment stage.
- Holds a display register that is updated only at frame boundaries, so digits never tear. Adds a blanking dead-time between digits and optional leading-zero suppression.

Parameters:
- DWELL, 50000: clocks per digit with enable asserted (ON phase), >=1.
- DEAD, 500: clocks per digit with enable deasserted (ghosting guard), >=1.
- CW, 16: counter width; must satisfy 2^CW > max(DWELL, DEAD).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- upd_valid  in  1  one-cycle request to load new display content.
- upd_data  in  16  four hex digits; [3:0] is digit 0, the rightmost.
- upd_dp  in  4  decimal point per digit, 1 = lit.
- lz_en  in  1  leading-zero suppression enable, sampled every cycle.
- upd_pending  out  1  new content is captured but not yet displayed.
- sel  out  2  digit index; goes to decoder i2.
- en  out  1  digit enable; goes to decoder en.
- hex  out  4  nibble of the selected digit.
- dp  out  1  decimal point of the selected digit.
- frame_tick  out  1  one-cycle pulse on the first ON cycle of digit 0.

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n). All state is in flops on clk and cleared by rst_n.
- Reset values:
  - state = DEAD, sel = 3, cnt = 0.
  - disp = 16'h0000, dp_reg = 4'h0, pend_data = 0, pend_dp = 0, upd_pending = 0.
  - en = 0, frame_tick = 0, hex = 0, dp = 0.
- State machine (two states):
  - ON: cnt counts 0..DWELL-1. At cnt == DWELL-1, go to DEAD and set cnt = 0.
  - DEAD: cnt counts 0..DEAD-1. At cnt == DEAD-1, go to ON, set cnt = 0, and sel <= sel+1 (wraps 3 -> 0).
- Frame boundary = the DEAD -> ON edge where sel wraps 3 -> 0. At that edge:
  - If upd_pending = 1: disp <= pend_data, dp_reg <= pend_dp, upd_pending <= 0.
  - frame_tick is registered high for exactly the following cycle.
- First frame_tick after reset: at cycle DEAD, counting the first clock after reset release as cycle 0.
- Timing:
  - Digit period = DWELL + DEAD clocks.
  - Frame period = 4 * (DWELL + DEAD) clocks.
- Update capture:
  - upd_valid = 1 on any edge: pend_data <= upd_data, pend_dp <= upd_dp, upd_pending <= 1.
  - If already pending, the latest write wins.
  - upd_valid on the frame-boundary edge itself: disp takes the old pending value; the new value goes into pending; upd_pending stays 1.
- Outputs:
  - Combinational from registers only; there is no input-to-output combinational path except lz_en into en.
  - hex = disp[4*sel +: 4], dp = dp_reg[sel]; both valid in ON and DEAD.
  - en = (state == ON) && !supp[sel].
- Suppression (supp):
  - lz_en = 0: supp = 0.
  - lz_en = 1:
    - supp[3] = (d3 == 0).
    - supp[2] = supp[3] && (d2 == 0).
    - supp[1] = supp[2] && (d1 == 0).
    - supp[0] = 0; digit 0 is never blanked.
  - A digit with its dp bit set is never suppressed.
- Reset asserted mid-operation: all registers return immediately (asynchronously) to their reset values. Pending content is lost.
- No combinational loops; sel changes only while en = 0.

Decomposition:
- Shared include seg7_defs.vh:
  - localparams ST_ON/ST_DEAD.
  - NUM_DIGITS = 4.
  - default DWELL/DEAD for a 50 MHz board.
- One sub-module, seg7_scan_timer: cnt plus state plus sel plus wrap detection. It outputs state, sel and a boundary strobe.
- Parent seg7_scan_ctrl holds the display/pending registers, the mux and the suppression logic.

Test Plan:
(Bench parameters DWELL = 4, DEAD = 2.)
1. Reset release, no updates:
   - en = 0 for cycles 0-1.
   - frame_tick at cycle 2 with sel = 0.
   - en pattern 4 high / 2 low repeating; sel sequence 0, 1, 2, 3 with period 6; frame_tick every 24 cycles.
2. upd_valid with data 16'h1234, dp 4'b0100, mid-frame:
   - upd_pending = 1 until the next boundary; old content (0000) is shown until then.
   - From frame_tick: hex = 4, 3, 2, 1 for sel 0-3; dp = 1 only at sel = 2; upd_pending = 0.
3. Two upd_valid writes (16'hAAAA, then 16'h5555) within one frame:
   - Next frame shows 5555 only.
4. upd_valid (16'h7777) on the exact boundary edge while 16'h1111 is pending:
   - That frame shows 1111; upd_pending stays 1.
   - Next frame shows 7777.
5. lz_en = 1, data 16'h0050, dp 0:
   - en stays low for sel 3 and 2; high for sel 1 (hex 5) and sel 0 (hex 0).
   - Data 16'h0000: only digit 0 enabled.
   - Set dp[3]: digit 3 enabled.
6. rst_n pulled low during an ON phase of sel = 1 with an update pending:
   - en = 0, sel = 3, upd_pending = 0 asynchronously.
   - After release, blank digits are displayed (disp = 0).

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg: shared states, defaults and leading-zero helper for the seven-segment scanner
package seg7_scan_ctrl_pkg;
  typedef enum logic {ST_ON = 1'b0, ST_DEAD = 1'b1} scan_state_e;
  localparam int NUM_DIGITS = 4;
  localparam int DEF_DWELL = 50000;
  localparam int DEF_DEAD = 500;
  localparam int DEF_CW = 16;
  function automatic logic [NUM_DIGITS-1:0] lz_supp(input logic [15:0] d, input logic [3:0] p,
                                                     input logic lz);
    logic [NUM_DIGITS-1:0] s;
    s[3] = lz && (d[15:12] == 4'h0) && !p[3];
    s[2] = s[3] && (d[11:8] == 4'h0) && !p[2];
    s[1] = s[2] && (d[7:4] == 4'h0) && !p[1];
    s[0] = 1'b0;
    return s;
  endfunction
endpackage

// File: rtl/seg7_scan_ctrl_timer.sv
// seg7_scan_ctrl_timer: ON/DEAD phase counter, digit select and frame-boundary strobe
module seg7_scan_ctrl_timer
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int DWELL = DEF_DWELL,
  parameter int DEAD  = DEF_DEAD,
  parameter int CW    = DEF_CW
) (
  input  logic        clk,
  input  logic        rst_n,
  output scan_state_e state,
  output logic [1:0]  sel,
  output logic        boundary
);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD - 1);
  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  // next phase: ON runs DWELL clocks, DEAD runs DEAD clocks then advances the digit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    sel_d   = sel_q;
    if (state_q == ST_ON && cnt_q == DWELL_LAST) begin
      state_d = ST_DEAD;
      cnt_d   = '0;
    end
    if (state_q == ST_DEAD && cnt_q == DEAD_LAST) begin
      state_d = ST_ON;
      cnt_d   = '0;
      sel_d   = sel_q + 2'd1;
    end
  end
  // phase registers; reset parks in DEAD on digit 3 so the first ON is a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DEAD;
      cnt_q   <= '0;
      sel_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end
  assign state    = state_q;
  assign sel      = sel_q;
  assign boundary = (state_q == ST_DEAD) && (cnt_q == DEAD_LAST) && (sel_q == 2'd3);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit seven-segment scan controller with tear-free updates and zero blanking
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int DWELL = DEF_DWELL,
  parameter int DEAD  = DEF_DEAD,
  parameter int CW    = DEF_CW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_dp,
  input  logic        lz_en,
  output logic        upd_pending,
  output logic [1:0]  sel,
  output logic        en,
  output logic [3:0]  hex,
  output logic        dp,
  output logic        frame_tick
);
  scan_state_e            state;
  logic                   boundary;
  logic [15:0]            disp_q, disp_d, pend_data_q, pend_data_d;
  logic [3:0]             dp_reg_q, dp_reg_d, pend_dp_q, pend_dp_d;
  logic                   pend_q, pend_d, tick_q, tick_d;
  logic [NUM_DIGITS-1:0]  supp;

  seg7_scan_ctrl_timer #(.DWELL(DWELL), .DEAD(DEAD), .CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state),
    .sel      (sel),
    .boundary (boundary)
  );

  // pending content moves to the display only at a frame start; a new write always lands in pending
  always_comb begin
    disp_d      = disp_q;
    dp_reg_d    = dp_reg_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_d      = pend_q;
    tick_d      = boundary;
    if (boundary && pend_q) begin
      disp_d   = pend_data_q;
      dp_reg_d = pend_dp_q;
      pend_d   = 1'b0;
    end
    if (upd_valid) begin
      pend_data_d = upd_data;
      pend_dp_d   = upd_dp;
      pend_d      = 1'b1;
    end
  end

  // display, pending and tick registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q      <= '0;
      dp_reg_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      disp_q      <= disp_d;
      dp_reg_q    <= dp_reg_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_q      <= pend_d;
      tick_q      <= tick_d;
    end
  end

  assign supp        = lz_supp(disp_q, dp_reg_q, lz_en);
  assign hex         = disp_q[{sel, 2'b00} +: 4];
  assign dp          = dp_reg_q[sel];
  assign en          = (state == ST_ON) && !supp[sel];
  assign upd_pending = pend_q;
  assign frame_tick  = tick_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of scan timing, frame-aligned updates, blanking and reset
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = '0;
  logic [3:0]  upd_dp = '0;
  logic        lz_en = 1'b0;
  logic        upd_pending, en, dp, frame_tick;
  logic [1:0]  sel;
  logic [3:0]  hex;
  int          checks = 0;
  int          errors = 0;

  seg7_scan_ctrl #(.DWELL(4), .DEAD(2), .CW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd_valid   (upd_valid),
    .upd_data    (upd_data),
    .upd_dp      (upd_dp),
    .lz_en       (lz_en),
    .upd_pending (upd_pending),
    .sel         (sel),
    .en          (en),
    .hex         (hex),
    .dp          (dp),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 60; i++) begin
      if (frame_tick === 1'b1) return;
      @(negedge clk);
    end
    chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] p);
    upd_valid = 1'b1;
    upd_data  = d;
    upd_dp    = p;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  // starts on the tick cycle, checks the first ON cycle of every digit, ends on the next tick cycle
  task automatic check_frame(input string tag, input logic [15:0] d, input logic [3:0] p,
                             input logic [3:0] enm, input logic [3:0] care);
    logic [3:0] nib;
    for (int k = 0; k < 4; k++) begin
      nib = d[4*k +: 4];
      chk({tag, "_sel"}, 32'(sel), 32'(k));
      chk({tag, "_hex"}, 32'(hex), 32'(nib));
      chk({tag, "_dp"}, 32'(dp), 32'(p[k]));
      if (care[k]) chk({tag, "_en"}, 32'(en), 32'(enm[k]));
      repeat (6) @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_en", 32'(en), 0);
    chk("rst_sel", 32'(sel), 3);
    chk("rst_pend", 32'(upd_pending), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_hex", 32'(hex), 0);
    chk("rst_dp", 32'(dp), 0);
    rst_n = 1'b1;
    chk("c0_en", 32'(en), 0);
    @(negedge clk);
    chk("c1_en", 32'(en), 0);
    chk("c1_tick", 32'(frame_tick), 0);
    @(negedge clk);
    for (int i = 0; i < 48; i++) begin
      chk("scan_en", 32'(en), 32'((i % 6) < 4));
      chk("scan_sel", 32'(sel), 32'((i / 6) % 4));
      chk("scan_tick", 32'(frame_tick), 32'((i % 24) == 0));
      @(negedge clk);
    end
    wait_tick();
    repeat (3) @(negedge clk);
    write(16'h1234, 4'b0100);
    chk("t2_pend", 32'(upd_pending), 1);
    chk("t2_old_hex", 32'(hex), 0);
    repeat (10) @(negedge clk);
    chk("t2_pend_hold", 32'(upd_pending), 1);
    chk("t2_old_hex2", 32'(hex), 0);
    wait_tick();
    chk("t2_pend_clr", 32'(upd_pending), 0);
    check_frame("t2", 16'h1234, 4'b0100, 4'b1111, 4'b1111);
    repeat (2) @(negedge clk);
    write(16'hAAAA, 4'b0000);
    repeat (3) @(negedge clk);
    write(16'h5555, 4'b0000);
    wait_tick();
    check_frame("t3", 16'h5555, 4'b0000, 4'b1111, 4'b1111);
    repeat (2) @(negedge clk);
    write(16'h1111, 4'b0000);
    repeat (20) @(negedge clk);
    write(16'h7777, 4'b0000);
    chk("t4_tick", 32'(frame_tick), 1);
    chk("t4_pend", 32'(upd_pending), 1);
    check_frame("t4a", 16'h1111, 4'b0000, 4'b1111, 4'b1111);
    chk("t4_pend_clr", 32'(upd_pending), 0);
    check_frame("t4b", 16'h7777, 4'b0000, 4'b1111, 4'b1111);
    lz_en = 1'b1;
    write(16'h0050, 4'b0000);
    wait_tick();
    check_frame("t5a", 16'h0050, 4'b0000, 4'b0011, 4'b1111);
    write(16'h0000, 4'b0000);
    wait_tick();
    check_frame("t5b", 16'h0000, 4'b0000, 4'b0001, 4'b1111);
    write(16'h0000, 4'b1000);
    wait_tick();
    check_frame("t5c", 16'h0000, 4'b1000, 4'b1001, 4'b1001);
    lz_en = 1'b0;
    write(16'h9999, 4'b1111);
    wait_tick();
    write(16'h4321, 4'b0011);
    repeat (5) @(negedge clk);
    chk("t6_pre_sel", 32'(sel), 1);
    chk("t6_pre_en", 32'(en), 1);
    chk("t6_pre_pend", 32'(upd_pending), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_en", 32'(en), 0);
    chk("t6_sel", 32'(sel), 3);
    chk("t6_pend", 32'(upd_pending), 0);
    chk("t6_hex", 32'(hex), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    chk("t6_pend_post", 32'(upd_pending), 0);
    check_frame("t6", 16'h0000, 4'b0000, 4'b1111, 4'b1111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
